// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: request/control bundle between the pipeline and pipe_ctrl.
//
// Signals:
//   jump_req_i / jump_addr_i : taken branch/jump from EXE and its target
//   hold_req_i               : EXE multi-cycle unit busy
//   ld_hazard_i              : ID load-use dependency
//   jump_o / jump_addr_o     : PC redirect strobe and target
//   if_id_flush_o            : IF/ID register loads a NOP
//   id_exe_flush_o           : ID/EXE register loads a NOP
//   stall_o                  : freeze enables, bit0 PC, bit1 IF/ID, bit2 ID/EXE
//   stall_cnt_o/flush_cnt_o  : performance event counters
//
// Modports: master = pipeline side (drives requests), slave = pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              jump_req_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              hold_req_i;
    logic              ld_hazard_i;
    logic              jump_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic              if_id_flush_o;
    logic              id_exe_flush_o;
    logic [2:0]        stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output jump_req_i,
        output jump_addr_i,
        output hold_req_i,
        output ld_hazard_i,
        input  jump_o,
        input  jump_addr_o,
        input  if_id_flush_o,
        input  id_exe_flush_o,
        input  stall_o,
        input  stall_cnt_o,
        input  flush_cnt_o
    );

    modport slave (
        input  jump_req_i,
        input  jump_addr_i,
        input  hold_req_i,
        input  ld_hazard_i,
        output jump_o,
        output jump_addr_o,
        output if_id_flush_o,
        output id_exe_flush_o,
        output stall_o,
        output stall_cnt_o,
        output flush_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline flush/stall controller for the 5-stage core.
//
// Arbitrates EXE redirects, EXE multi-cycle holds and ID load-use hazards
// (priority reset > jump > hold > load-use), stretches each accepted jump
// into FLUSH_CYCLES cycles of IF/ID + ID/EXE flush, and counts stall cycles
// and accepted jumps.
//
// Ports:
//   clk_i : core clock, all state on rising edge
//   rst_i : synchronous active-high reset
//   bus   : pipe_ctrl_if.slave (requests in, flush/stall/jump/counters out)
//
// Control outputs are combinational from current state and current
// requests; the pipeline registers sample them at the next edge.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal operation, requests arbitrated by priority
// REDIRECT | trailing flush cycles of an accepted jump; hold/load-use ignored
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32,
    parameter int ADDR_W       = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    pipe_ctrl_if.slave   bus
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_e;

    localparam logic [1:0] REM_LOAD = 2'(FLUSH_CYCLES - 1);
    localparam bit         MULTI    = (FLUSH_CYCLES > 1);

    state_e            state_q, state_d;
    logic [1:0]        rem_q, rem_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic              if_id_flush;
    logic              id_exe_flush;
    logic [2:0]        stall;

    // Output decode. Requests from flushed instructions (hold, load-use)
    // are masked while trailing flush cycles are in progress.
    always_comb begin
        jump         = 1'b0;
        jump_addr    = '0;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        stall        = 3'b000;
        if (rst_i) begin
            jump = 1'b0;
        end else if (bus.jump_req_i) begin
            jump         = 1'b1;
            jump_addr    = bus.jump_addr_i;
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (state_q == REDIRECT) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (bus.hold_req_i) begin
            stall = 3'b111;
        end else if (bus.ld_hazard_i) begin
            // Freeze PC and IF/ID, push a bubble into ID/EXE.
            stall        = 3'b011;
            id_exe_flush = 1'b1;
        end
    end

    // Next-state and counter decode.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.jump_req_i) begin
            // A jump during REDIRECT restarts the flush window.
            flush_cnt_d = flush_cnt_q + 1'b1;
            if (MULTI) begin
                state_d = REDIRECT;
                rem_d   = REM_LOAD;
            end else begin
                state_d = RUN;
                rem_d   = 2'd0;
            end
        end else if (state_q == REDIRECT) begin
            if (rem_q <= 2'd1) begin
                state_d = RUN;
                rem_d   = 2'd0;
            end else begin
                rem_d = rem_q - 2'd1;
            end
        end
        if (|stall) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            rem_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.jump_o         = jump;
    assign bus.jump_addr_o    = jump_addr;
    assign bus.if_id_flush_o  = if_id_flush;
    assign bus.id_exe_flush_o = id_exe_flush;
    assign bus.stall_o        = stall;
    assign bus.stall_cnt_o    = stall_cnt_q;
    assign bus.flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (3 flush cycles / 32-bit
// counters, 1 flush cycle / 4-bit counters) share one stimulus stream.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.ADDR_W(32), .CNT_W(32)) if0 ();
    pipe_ctrl_if #(.ADDR_W(32), .CNT_W(4))  if1 ();

    pipe_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32), .ADDR_W(32)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if0.slave)
    );

    pipe_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4), .ADDR_W(32)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if1.slave)
    );

    typedef struct {
        logic        jump;
        logic [31:0] addr;
        logic        fi;
        logic        fe;
        logic [2:0]  stall;
        bit          cnt_valid;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: flush cycles still owed after the current one,
    // and event totals (masked to counter width on compare).
    int          flush_left [2];
    logic [31:0] m_scnt [2];
    logic [31:0] m_fcnt [2];
    bit          cnt_known [2];

    function automatic int fc_of(int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic logic [31:0] mask_of(int d);
        return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    // Applies one cycle of stimulus and pushes each instance's expected view.
    task automatic drive(input bit r, input bit j, input bit h, input bit l, input logic [31:0] a);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        if0.jump_req_i = j;  if1.jump_req_i = j;
        if0.hold_req_i = h;  if1.hold_req_i = h;
        if0.ld_hazard_i = l; if1.ld_hazard_i = l;
        if0.jump_addr_i = a; if1.jump_addr_i = a;
        for (int d = 0; d < 2; d++) begin
            e.jump = 1'b0; e.addr = 32'h0; e.fi = 1'b0; e.fe = 1'b0; e.stall = 3'b000;
            e.cnt_valid = cnt_known[d];
            e.scnt = m_scnt[d] & mask_of(d);
            e.fcnt = m_fcnt[d] & mask_of(d);
            if (r) begin
                flush_left[d] = 0;
                m_scnt[d] = 32'h0;
                m_fcnt[d] = 32'h0;
                cnt_known[d] = 1'b1;
            end else if (j) begin
                e.jump = 1'b1; e.addr = a; e.fi = 1'b1; e.fe = 1'b1;
                m_fcnt[d] = m_fcnt[d] + 32'h1;
                flush_left[d] = fc_of(d) - 1;
            end else if (flush_left[d] > 0) begin
                e.fi = 1'b1; e.fe = 1'b1;
                flush_left[d] = flush_left[d] - 1;
            end else if (h) begin
                e.stall = 3'b111;
                m_scnt[d] = m_scnt[d] + 32'h1;
            end else if (l) begin
                e.stall = 3'b011; e.fe = 1'b1;
                m_scnt[d] = m_scnt[d] + 32'h1;
            end
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic compare(input int d, input exp_t e, input logic jmp, input logic [31:0] addr,
                           input logic fi, input logic fe, input logic [2:0] st,
                           input logic [31:0] sc, input logic [31:0] fc);
        chk("jump_o", d, {31'h0, jmp}, {31'h0, e.jump});
        chk("jump_addr_o", d, addr, e.addr);
        chk("if_id_flush_o", d, {31'h0, fi}, {31'h0, e.fi});
        chk("id_exe_flush_o", d, {31'h0, fe}, {31'h0, e.fe});
        chk("stall_o", d, {29'h0, st}, {29'h0, e.stall});
        if (e.cnt_valid) begin
            chk("stall_cnt_o", d, sc, e.scnt);
            chk("flush_cnt_o", d, fc, e.fcnt);
        end
    endtask

    // Monitor: outputs are valid every cycle; sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                compare(0, e, if0.jump_o, if0.jump_addr_o, if0.if_id_flush_o, if0.id_exe_flush_o,
                        if0.stall_o, if0.stall_cnt_o, if0.flush_cnt_o);
            end
            if (q1.size() != 0) begin
                e = q1.pop_front();
                compare(1, e, if1.jump_o, if1.jump_addr_o, if1.if_id_flush_o, if1.id_exe_flush_o,
                        if1.stall_o, {28'h0, if1.stall_cnt_o}, {28'h0, if1.flush_cnt_o});
            end
        end
    end

    initial begin
        rst = 1'b1;
        if0.jump_req_i = 1'b0; if1.jump_req_i = 1'b0;
        if0.hold_req_i = 1'b0; if1.hold_req_i = 1'b0;
        if0.ld_hazard_i = 1'b0; if1.ld_hazard_i = 1'b0;
        if0.jump_addr_i = 32'h0; if1.jump_addr_i = 32'h0;
        for (int d = 0; d < 2; d++) begin
            flush_left[d] = 0; m_scnt[d] = 32'h0; m_fcnt[d] = 32'h0; cnt_known[d] = 1'b0;
        end

        // Reset with every request high.
        drive(1, 1, 1, 1, 32'hDEAD_BEEF);
        drive(1, 1, 1, 1, 32'hDEAD_BEEF);
        drive(0, 0, 0, 0, 32'h0);
        // Single jump.
        drive(0, 1, 0, 0, 32'h0000_0100);
        repeat (4) drive(0, 0, 0, 0, 32'h1234_5678);
        // Jump, load-use during the flush window, then a second jump.
        drive(0, 1, 0, 0, 32'h0000_0200);
        drive(0, 0, 0, 1, 32'h0);
        repeat (3) drive(0, 0, 0, 0, 32'h0);
        drive(0, 1, 0, 0, 32'h0000_0300);
        drive(0, 1, 0, 0, 32'h0000_0304);
        repeat (4) drive(0, 0, 1, 0, 32'h0);
        // Hold for 4 then load-use.
        drive(1, 0, 0, 0, 32'h0);
        repeat (4) drive(0, 0, 1, 0, 32'h0);
        drive(0, 0, 0, 1, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        // Hold with load-use, then jump+hold+load-use.
        drive(0, 0, 1, 1, 32'h0);
        drive(0, 1, 1, 1, 32'h0000_0400);
        repeat (3) drive(0, 0, 1, 1, 32'h0);
        // Reset in the middle of the flush window.
        drive(0, 1, 0, 0, 32'h0000_0500);
        drive(1, 0, 0, 0, 32'h0);
        repeat (3) drive(0, 0, 1, 0, 32'h0);
        // Counter wrap: 17 holds after reset.
        drive(1, 0, 0, 0, 32'h0);
        repeat (17) drive(0, 0, 1, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30), $urandom);
        end
        drive(0, 0, 0, 0, 32'h0);

        repeat (3) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d entries left expected 0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 5-stage core. It drives the per-stage flush and stall signals that the IF/ID and ID/EXE pipeline registers and the PC sample. It takes branch/jump redirect requests and multi-cycle hold requests from EXE, and load-use hazard requests from ID. It arbitrates between them, sequences multi-cycle redirect flushes, and keeps stall/flush event counters for performance monitoring.

## Interface

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles both flushes are asserted per accepted jump (legal 1..4).
- CNT_W, 32, width of the event counters.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high (`RstEnable`).
- jump_req_i  in  1  EXE resolved a taken branch or jump this cycle.
- jump_addr_i  in  `InstAddrBus`  redirect target, valid with jump_req_i.
- hold_req_i  in  1  EXE multi-cycle unit busy; freeze the front end.
- ld_hazard_i  in  1  ID detected a load-use dependency.
- jump_o  out  1  PC loads jump_addr_o this cycle.
- jump_addr_o  out  `InstAddrBus`  redirect target to PC.
- if_id_flush_o  out  1  `FlushEnable` when the IF/ID register must load a NOP.
- id_exe_flush_o  out  1  `FlushEnable` when the ID/EXE register must load a NOP.
- stall_o  out  3  freeze enables: bit0 PC, bit1 IF/ID, bit2 ID/EXE.
- stall_cnt_o  out  CNT_W  cycles with any stall_o bit set.
- flush_cnt_o  out  CNT_W  accepted jump requests.

## Operation

- Control outputs are combinational, decoded from the current state and current inputs. Pipeline registers sample them at the next edge.
- State register: RUN, REDIRECT. Remaining-flush counter rem (2 bits).
- Request priority: rst_i > jump_req_i > hold_req_i > ld_hazard_i.

In RUN:
- jump_req_i:
  - jump_o=1, jump_addr_o=jump_addr_i, both flushes=1, stall_o=0.
  - If FLUSH_CYCLES>1: next state REDIRECT, rem=FLUSH_CYCLES-1. Otherwise stay in RUN.
  - flush_cnt_o increments.
- Else hold_req_i: stall_o=3'b111, no flush, jump_o=0.
- Else ld_hazard_i: stall_o=3'b011, id_exe_flush_o=1 (bubble insertion), if_id_flush_o=0.
- Else all outputs idle: stall_o=0, flushes=0, jump_o=0.

In REDIRECT:
- Both flushes=1, jump_o=0, stall_o=0.
- hold_req_i and ld_hazard_i are ignored, because they originate from instructions being flushed.
- rem decrements. When rem==1, next state is RUN.
- A jump_req_i in REDIRECT is accepted as in RUN. It sets jump_o=1, reloads rem=FLUSH_CYCLES-1 (or returns to RUN if FLUSH_CYCLES==1), and increments flush_cnt_o.

Other rules:
- jump_addr_o is 0 whenever jump_o=0.
- Counters wrap modulo 2^CNT_W; no saturation.
- stall_cnt_o increments on every cycle where any stall_o bit is 1 and rst_i=0.

## Timing

Reset:
- While rst_i is high: state=RUN, rem=0, both counters=0.
- Combinational outputs are forced idle: jump_o=0, jump_addr_o=0, both flushes `FlushDisable`, stall_o=0.
- Reset asserted mid-REDIRECT aborts the remaining flush cycles. On the first cycle after rst_i falls, the unit is in RUN.

Latency:
- Zero-cycle request-to-control-output path.
- The redirect PC and the NOPs take effect at the next rising edge.
- Counters update at the same edge and are visible one cycle after the event.

Boundary conditions:
- jump_req_i with hold_req_i in the same cycle: jump wins, stall_o=0, stall_cnt unchanged.
- hold_req_i with ld_hazard_i: stall_o=3'b111, no flush.
- FLUSH_CYCLES=1: REDIRECT is never entered.
- Held hold_req_i for N cycles: stall_o=3'b111 for exactly N cycles, stall_cnt +N.

## Test plan

- Reset: drive rst_i=1 for 2 cycles with all requests high. Required: every output idle and counters 0 during reset; state RUN after release.
- Single jump, FLUSH_CYCLES=1: jump_req_i=1 with addr 0x0000_0100 for one cycle. Required: same cycle jump_o=1, jump_addr_o=0x100, both flushes=1; next cycle idle; flush_cnt_o=1.
- FLUSH_CYCLES=3:
  - Jump at cycle 0. Required: flushes=1 for cycles 0–2; jump_o=1 only at cycle 0; ld_hazard_i at cycle 1 has no effect.
  - A second jump at cycle 1. Required: flushes extend through cycle 3; flush_cnt_o=2.
- Hold then load-use: hold_req_i=1 for 4 cycles, then ld_hazard_i=1 for 1 cycle. Required: stall_o=111 for 4 cycles, then stall_o=011 with id_exe_flush_o=1; stall_cnt_o=5.
- Simultaneous events:
  - jump+hold+ld_hazard in one cycle. Required: jump behaviour only; stall_o=0.
  - rst_i asserted during REDIRECT. Required: flushes drop in the same cycle; counters cleared.
- Counter wrap: CNT_W=4, 17 hold cycles. Required: stall_cnt_o=1.
